// File: rtl/avalon_xbar_arbiter_if.sv
// Bus-side signals between the Avalon crossbar and its per-slave arbiter.
// The 'master' modport drives requests and handshakes; 'slave' is the arbiter side.
interface avalon_xbar_arbiter_if #(
  parameter int NUM_MASTERS = 5,
  parameter int NUM_SLAVES  = 4,
  parameter int SEL_W       = $clog2(NUM_MASTERS + 1)
);
  logic [NUM_MASTERS*NUM_SLAVES-1:0] i_M_SReq;
  logic [NUM_MASTERS-1:0]            i_AVIn_Read;
  logic [NUM_MASTERS-1:0]            i_AVIn_Write;
  logic [8*NUM_MASTERS-1:0]          i_AVIn_BurstCount;
  logic [NUM_SLAVES-1:0]             i_AVOut_WaitRequest;
  logic [NUM_SLAVES-1:0]             i_AVOut_ReadDataValid;
  logic [SEL_W*NUM_SLAVES-1:0]       o_MuxSel;
  logic [NUM_MASTERS*NUM_SLAVES-1:0] o_Grant;

  modport master (
    output i_M_SReq, i_AVIn_Read, i_AVIn_Write, i_AVIn_BurstCount,
    output i_AVOut_WaitRequest, i_AVOut_ReadDataValid,
    input  o_MuxSel, o_Grant
  );
  modport slave (
    input  i_M_SReq, i_AVIn_Read, i_AVIn_Write, i_AVIn_BurstCount,
    input  i_AVOut_WaitRequest, i_AVOut_ReadDataValid,
    output o_MuxSel, o_Grant
  );
endinterface

// File: rtl/avalon_xbar_arbiter.sv
// Avalon crossbar arbiter: one round-robin grant engine per slave port, each holding its
// grant until any accepted burst completes. Drives mux selects and one-hot grants.
module avalon_xbar_arbiter_engine #(
  parameter int NUM_MASTERS = 5,
  parameter int SEL_W       = 3,
  parameter int HOLD_LIMIT  = 4
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_n,
  input  logic [NUM_MASTERS-1:0]      req,
  input  logic [NUM_MASTERS-1:0]      avail,
  input  logic [NUM_MASTERS-1:0]      rd,
  input  logic [NUM_MASTERS-1:0]      wr,
  input  logic [NUM_MASTERS-1:0][7:0] bcnt,
  input  logic                        wait_req,
  input  logic                        rvalid,
  output logic [SEL_W-1:0]            sel_q
);
  localparam logic [SEL_W-1:0] IDLE_SEL = SEL_W'(NUM_MASTERS);
  typedef enum logic [1:0] {IDLE, GNT, WR_BURST, RD_WAIT} state_e;

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       sel_d, ptr_q, ptr_d, pick;
  logic [7:0]             txn_q, txn_d, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [7:0]             own_bc, bc1, txn_inc;
  logic [NUM_MASTERS-1:0] own_oh, cand;
  logic                   own_rd, own_wr, own_req, others, pick_vld, hold_hit;

  always_comb begin
    own_oh = '0;
    own_bc = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      own_oh[m] = (sel_q == SEL_W'(m));
      if (own_oh[m]) own_bc = bcnt[m];
    end
    own_rd  = |(rd & own_oh);
    own_wr  = |(wr & own_oh);
    own_req = |(req & own_oh);
    others  = |(req & ~own_oh);
    bc1     = (own_bc == 8'd0) ? 8'd1 : own_bc;
    txn_inc = (txn_q == 8'hFF) ? txn_q : txn_q + 8'd1;
    // >= rather than == so a requester arriving after the limit still gets its turn
    hold_hit = (HOLD_LIMIT != 0) && (txn_q >= 8'(HOLD_LIMIT)) && others;
    // Round robin: lowest candidate above the pointer, else lowest overall
    cand     = req & avail;
    pick_vld = 1'b0;
    pick     = IDLE_SEL;
    for (int m = NUM_MASTERS - 1; m >= 0; m--)
      if (cand[m]) begin
        pick_vld = 1'b1;
        pick     = SEL_W'(m);
      end
    for (int m = NUM_MASTERS - 1; m >= 0; m--)
      if (cand[m] && (SEL_W'(m) > ptr_q)) pick = SEL_W'(m);
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    txn_d    = txn_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      IDLE: if (pick_vld) begin
        state_d = GNT;
        sel_d   = pick;
        ptr_d   = pick;
        txn_d   = '0;
      end
      GNT: begin
        if (hold_hit || (!own_req && !((own_rd || own_wr) && !wait_req))) begin
          state_d = IDLE;
          sel_d   = IDLE_SEL;
        end else if (own_rd && !wait_req) begin
          rd_cnt_d = bc1;
          txn_d    = txn_inc;
          state_d  = RD_WAIT;
        end else if (own_wr && !wait_req) begin
          if (own_bc > 8'd1) begin
            wr_cnt_d = own_bc - 8'd1;
            state_d  = WR_BURST;
          end else begin
            txn_d = txn_inc;
          end
        end
      end
      WR_BURST: if (own_wr && !wait_req && (wr_cnt_q != 8'd0)) begin
        wr_cnt_d = wr_cnt_q - 8'd1;
        if (wr_cnt_q == 8'd1) begin
          txn_d   = txn_inc;
          state_d = GNT;
        end
      end
      RD_WAIT: if (rvalid && (rd_cnt_q != 8'd0)) begin
        rd_cnt_d = rd_cnt_q - 8'd1;
        if (rd_cnt_q == 8'd1) state_d = GNT;
      end
      default: begin
        state_d = IDLE;
        sel_d   = IDLE_SEL;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q  <= IDLE;
      sel_q    <= IDLE_SEL;
      ptr_q    <= SEL_W'(NUM_MASTERS - 1);
      txn_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      txn_q    <= txn_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end
endmodule

module avalon_xbar_arbiter #(
  parameter int NUM_MASTERS = 5,
  parameter int NUM_SLAVES  = 4,
  parameter int SEL_W       = $clog2(NUM_MASTERS + 1),
  parameter int HOLD_LIMIT  = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  avalon_xbar_arbiter_if.slave  bus
);
  logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0] req, avail;
  logic [NUM_SLAVES-1:0][SEL_W-1:0]       sel;
  logic [NUM_MASTERS-1:0][7:0]            bcnt;

  // A master asking for several slaves only counts toward its lowest-index one
  always_comb begin
    req = '0;
    for (int m = 0; m < NUM_MASTERS; m++)
      for (int s = 0; s < NUM_SLAVES; s++) begin
        req[s][m] = bus.i_M_SReq[m*NUM_SLAVES + s];
        for (int t = 0; t < s; t++)
          if (bus.i_M_SReq[m*NUM_SLAVES + t]) req[s][m] = 1'b0;
      end
  end

  // Masters already owning another slave may not be picked
  always_comb begin
    avail = '1;
    for (int s = 0; s < NUM_SLAVES; s++)
      for (int t = 0; t < NUM_SLAVES; t++)
        for (int m = 0; m < NUM_MASTERS; m++)
          if ((t != s) && (sel[t] == SEL_W'(m))) avail[s][m] = 1'b0;
  end

  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) bcnt[m] = bus.i_AVIn_BurstCount[8*m +: 8];
  end

  always_comb begin
    bus.o_MuxSel = '0;
    bus.o_Grant  = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      bus.o_MuxSel[SEL_W*s +: SEL_W] = sel[s];
      for (int m = 0; m < NUM_MASTERS; m++)
        bus.o_Grant[m*NUM_SLAVES + s] = (sel[s] == SEL_W'(m));
    end
  end

  generate
    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_eng
      avalon_xbar_arbiter_engine #(
        .NUM_MASTERS(NUM_MASTERS), .SEL_W(SEL_W), .HOLD_LIMIT(HOLD_LIMIT)
      ) u_eng (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .req      (req[s]),
        .avail    (avail[s]),
        .rd       (bus.i_AVIn_Read),
        .wr       (bus.i_AVIn_Write),
        .bcnt     (bcnt),
        .wait_req (bus.i_AVOut_WaitRequest[s]),
        .rvalid   (bus.i_AVOut_ReadDataValid[s]),
        .sel_q    (sel[s])
      );
    end
  endgenerate
endmodule

// File: tb/tb_avalon_xbar_arbiter.sv
// Bench for avalon_xbar_arbiter: directed scenarios plus randomized traffic checked
// each cycle against an owner/ptr/pending-beats model of every slave port.
module tb_avalon_xbar_arbiter;
  localparam int NM = 5, NS = 4, SW = 3, HL = 4;
  localparam logic [NS*SW-1:0] ALL_IDLE = {NS{3'd5}};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  avalon_xbar_arbiter_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SEL_W(SW)) bus();
  avalon_xbar_arbiter #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SEL_W(SW), .HOLD_LIMIT(HL))
    dut (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus));

  int n_cmp = 0, n_bad = 0;
  // Reference: who owns each slave, RR pointer, transactions this grant, beats outstanding
  int owner[NS], ptr[NS], txns[NS], wr_left[NS], rd_left[NS];

  function automatic int lowslv(int m);
    for (int s = 0; s < NS; s++) if (bus.i_M_SReq[m*NS + s]) return s;
    return -1;
  endfunction

  function automatic bit held_elsewhere(int m, int s);
    for (int t = 0; t < NS; t++) if (t != s && owner[t] == m) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NS*SW-1:0] exp_sel();
    logic [NS*SW-1:0] v;
    for (int s = 0; s < NS; s++) v[SW*s +: SW] = (owner[s] < 0) ? SW'(NM) : SW'(owner[s]);
    return v;
  endfunction

  function automatic logic [NM*NS-1:0] exp_gnt();
    logic [NM*NS-1:0] v = '0;
    for (int s = 0; s < NS; s++) if (owner[s] >= 0) v[owner[s]*NS + s] = 1'b1;
    return v;
  endfunction

  function automatic logic [SW-1:0] sel_of(int s);
    return bus.o_MuxSel[SW*s +: SW];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      owner[s] = -1; ptr[s] = NM - 1; txns[s] = 0; wr_left[s] = 0; rd_left[s] = 0;
    end
  endtask

  task automatic model_step();
    int nown[NS], nptr[NS], ntx[NS], nwr[NS], nrd[NS], low[NM];
    for (int m = 0; m < NM; m++) low[m] = lowslv(m);
    for (int s = 0; s < NS; s++) begin
      nown[s] = owner[s]; nptr[s] = ptr[s]; ntx[s] = txns[s];
      nwr[s] = wr_left[s]; nrd[s] = rd_left[s];
      if (owner[s] < 0) begin
        for (int i = 1; i <= NM; i++) begin
          int m;
          m = (ptr[s] + i) % NM;
          if (low[m] == s && !held_elsewhere(m, s)) begin
            nown[s] = m; nptr[s] = m; ntx[s] = 0;
            break;
          end
        end
      end else begin
        int o, b;
        bit acc_r, acc_w, waiting;
        o = owner[s];
        b = (bus.i_AVIn_BurstCount[8*o +: 8] == 0) ? 1 : int'(bus.i_AVIn_BurstCount[8*o +: 8]);
        acc_r = bus.i_AVIn_Read[o] && !bus.i_AVOut_WaitRequest[s];
        acc_w = bus.i_AVIn_Write[o] && !bus.i_AVOut_WaitRequest[s];
        waiting = 1'b0;
        for (int m = 0; m < NM; m++) if (m != o && low[m] == s) waiting = 1'b1;
        if (rd_left[s] > 0) begin
          if (bus.i_AVOut_ReadDataValid[s]) nrd[s] = rd_left[s] - 1;
        end else if (wr_left[s] > 0) begin
          if (acc_w) begin
            nwr[s] = wr_left[s] - 1;
            if (nwr[s] == 0) ntx[s] = (txns[s] < 255) ? txns[s] + 1 : 255;
          end
        end else if (txns[s] >= HL && waiting) begin
          nown[s] = -1;
        end else if (acc_r) begin
          nrd[s] = b; ntx[s] = (txns[s] < 255) ? txns[s] + 1 : 255;
        end else if (acc_w) begin
          if (b > 1) nwr[s] = b - 1;
          else ntx[s] = (txns[s] < 255) ? txns[s] + 1 : 255;
        end else if (low[o] != s) begin
          nown[s] = -1;
        end
      end
    end
    for (int s = 0; s < NS; s++) begin
      owner[s] = nown[s]; ptr[s] = nptr[s]; txns[s] = ntx[s];
      wr_left[s] = nwr[s]; rd_left[s] = nrd[s];
    end
  endtask

  task automatic cycle();
    if (!rst_n) model_reset(); else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_M_SReq = '0; bus.i_AVIn_Read = '0; bus.i_AVIn_Write = '0;
    bus.i_AVIn_BurstCount = '0; bus.i_AVOut_WaitRequest = '0; bus.i_AVOut_ReadDataValid = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) cycle();
    n_cmp++; if (bus.o_MuxSel !== ALL_IDLE) begin n_bad++; $display("FAIL reset_sel: got %h want %h", bus.o_MuxSel, ALL_IDLE); end
    n_cmp++; if (bus.o_Grant !== '0) begin n_bad++; $display("FAIL reset_gnt: got %h want 0", bus.o_Grant); end
    rst_n = 1'b1;
    cycle();
    n_cmp++; if (bus.o_MuxSel !== ALL_IDLE) begin n_bad++; $display("FAIL post_reset_sel: got %h want %h", bus.o_MuxSel, ALL_IDLE); end
  endtask

  task automatic test_single_grant();
    bus.i_M_SReq[2*NS + 1] = 1'b1;
    cycle();
    n_cmp++; if (sel_of(1) !== 3'd2) begin n_bad++; $display("FAIL grant_sel: got %0d want 2", sel_of(1)); end
    n_cmp++; if (bus.o_Grant !== 20'h00200) begin n_bad++; $display("FAIL grant_bit: got %h want 00200", bus.o_Grant); end
    cycle();
    n_cmp++; if (sel_of(1) !== 3'd2) begin n_bad++; $display("FAIL grant_hold: got %0d want 2", sel_of(1)); end
    bus.i_M_SReq[2*NS + 1] = 1'b0;
    cycle();
    n_cmp++; if (sel_of(1) !== 3'd5) begin n_bad++; $display("FAIL grant_release: got %0d want 5", sel_of(1)); end
  endtask

  task automatic test_round_robin();
    logic [SW-1:0] want[8] = '{3'd0, 3'd0, 3'd5, 3'd3, 3'd3, 3'd5, 3'd0, 3'd5};
    for (int k = 0; k < 8; k++) begin
      clear_inputs();
      case (k)
        0: begin bus.i_M_SReq[0] = 1'b1; bus.i_M_SReq[3*NS] = 1'b1; end
        1: begin bus.i_M_SReq[0] = 1'b1; bus.i_M_SReq[3*NS] = 1'b1;
                 bus.i_AVIn_Write[0] = 1'b1; bus.i_AVIn_BurstCount[7:0] = 8'd1; end
        2, 3: bus.i_M_SReq[3*NS] = 1'b1;
        4: begin bus.i_M_SReq[3*NS] = 1'b1; bus.i_AVIn_Write[3] = 1'b1;
                 bus.i_AVIn_BurstCount[31:24] = 8'd1; end
        5, 6: bus.i_M_SReq[0] = 1'b1;
        default: ;
      endcase
      cycle();
      n_cmp++; if (sel_of(0) !== want[k]) begin n_bad++; $display("FAIL rr_step%0d: got %0d want %0d", k, sel_of(0), want[k]); end
    end
  endtask

  task automatic test_write_burst();
    clear_inputs();
    bus.i_M_SReq[1*NS + 2] = 1'b1;
    cycle();
    n_cmp++; if (sel_of(2) !== 3'd1) begin n_bad++; $display("FAIL wb_grant: got %0d want 1", sel_of(2)); end
    bus.i_AVIn_Write[1] = 1'b1; bus.i_AVIn_BurstCount[15:8] = 8'd4;
    cycle();
    bus.i_M_SReq[1*NS + 2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.i_AVOut_WaitRequest[2] = (k < 2);
      cycle();
      n_cmp++; if (sel_of(2) !== 3'd1) begin n_bad++; $display("FAIL wb_hold%0d: got %0d want 1", k, sel_of(2)); end
    end
    bus.i_AVIn_Write[1] = 1'b0;
    cycle();
    n_cmp++; if (sel_of(2) !== 3'd5) begin n_bad++; $display("FAIL wb_release: got %0d want 5", sel_of(2)); end
  endtask

  task automatic test_read_burst();
    clear_inputs();
    bus.i_M_SReq[4*NS + 3] = 1'b1;
    cycle();
    n_cmp++; if (sel_of(3) !== 3'd4) begin n_bad++; $display("FAIL rb_grant: got %0d want 4", sel_of(3)); end
    bus.i_AVIn_Read[4] = 1'b1; bus.i_AVIn_BurstCount[39:32] = 8'd3;
    cycle();
    bus.i_AVIn_Read[4] = 1'b0; bus.i_M_SReq[4*NS + 3] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      bus.i_AVOut_ReadDataValid[3] = (k == 2 || k == 5 || k == 6);
      cycle();
      n_cmp++; if (sel_of(3) !== ((k <= 6) ? 3'd4 : 3'd5)) begin
        n_bad++; $display("FAIL rb_cycle%0d: got %0d want %0d", k, sel_of(3), (k <= 6) ? 4 : 5); end
    end
  endtask

  task automatic test_hold_limit();
    clear_inputs();
    bus.i_M_SReq[0] = 1'b1;
    cycle();
    n_cmp++; if (sel_of(0) !== 3'd0) begin n_bad++; $display("FAIL hl_grant: got %0d want 0", sel_of(0)); end
    bus.i_M_SReq[1*NS] = 1'b1; bus.i_AVIn_Write[0] = 1'b1; bus.i_AVIn_BurstCount[7:0] = 8'd1;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      n_cmp++; if (sel_of(0) !== ((k <= 4) ? 3'd0 : (k == 5) ? 3'd5 : 3'd1)) begin
        n_bad++; $display("FAIL hl_cycle%0d: got %0d want %0d", k, sel_of(0), (k <= 4) ? 0 : (k == 5) ? 5 : 1); end
    end
    clear_inputs();
    repeat (2) cycle();
  endtask

  task automatic test_reset_mid_burst();
    clear_inputs();
    bus.i_M_SReq[2*NS] = 1'b1;
    cycle();
    n_cmp++; if (sel_of(0) !== 3'd2) begin n_bad++; $display("FAIL rmb_grant: got %0d want 2", sel_of(0)); end
    bus.i_AVIn_Write[2] = 1'b1; bus.i_AVIn_BurstCount[23:16] = 8'd8;
    repeat (2) cycle();
    rst_n = 1'b0;
    cycle();
    n_cmp++; if (bus.o_MuxSel !== ALL_IDLE) begin n_bad++; $display("FAIL rmb_reset: got %h want %h", bus.o_MuxSel, ALL_IDLE); end
    rst_n = 1'b1; bus.i_AVIn_Write[2] = 1'b0; bus.i_M_SReq[3*NS + 1] = 1'b1;
    cycle();
    n_cmp++; if (sel_of(0) !== 3'd2) begin n_bad++; $display("FAIL rmb_regrant0: got %0d want 2", sel_of(0)); end
    n_cmp++; if (sel_of(1) !== 3'd3) begin n_bad++; $display("FAIL rmb_regrant1: got %0d want 3", sel_of(1)); end
    clear_inputs();
    repeat (2) cycle();
  endtask

  task automatic test_random();
    logic [NS-1:0] v;
    int r;
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      for (int m = 0; m < NM; m++) begin
        if ($urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 9);
          v = '0;
          if (r >= 3 && r < 9) v[$urandom_range(0, NS-1)] = 1'b1;
          else if (r == 9) v = NS'($urandom);
          for (int s = 0; s < NS; s++) bus.i_M_SReq[m*NS + s] = v[s];
        end
        bus.i_AVIn_Read[m]  = ($urandom_range(0, 3) == 0);
        bus.i_AVIn_Write[m] = ($urandom_range(0, 2) == 0);
        bus.i_AVIn_BurstCount[8*m +: 8] = 8'($urandom_range(0, 4));
      end
      for (int s = 0; s < NS; s++) begin
        bus.i_AVOut_WaitRequest[s]   = ($urandom_range(0, 3) == 0);
        bus.i_AVOut_ReadDataValid[s] = ($urandom_range(0, 2) == 0);
      end
      cycle();
      n_cmp++; if (bus.o_MuxSel !== exp_sel()) begin n_bad++; $display("FAIL rnd_sel c%0d: got %h want %h", c, bus.o_MuxSel, exp_sel()); end
      n_cmp++; if (bus.o_Grant !== exp_gnt()) begin n_bad++; $display("FAIL rnd_gnt c%0d: got %h want %h", c, bus.o_Grant, exp_gnt()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_grant();
    test_round_robin();
    test_write_burst();
    test_read_burst();
    test_hold_limit();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
